// File: rtl/replay_buffer_mux.sv
// replay_buffer_mux
// Ping-pong replay buffer for a multiplexed macro-column. One bank captures NUM_INPUTS
// P-bit spike vectors per slot during a gamma cycle. On each grst the banks swap and the
// closed bank is streamed out group-major (g0 s0..sL-1, g1 s0.., ...) over valid/ready.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_grst              gamma-cycle boundary pulse (swap banks, start replay)
//   i_in_valid          i_data_in holds one slot for all groups (group g at [g*P +: P])
//   o_out_valid         o_data_out holds a replay word; i_out_ready accepts it
//   o_data_out          replayed spike vector (0 while o_out_valid is low)
//   o_out_grp/o_out_slot group and slot index of the current word
//   o_out_last          final word of the current replay
//   o_wr_bank           bank currently being written
//   o_wr_ovf            sticky: a write was dropped because the bank was full
//   o_rd_ovr            sticky: grst arrived before the replay finished
module replay_buffer_mux #(
  parameter int unsigned NUM_INPUTS   = 3,
  parameter int unsigned BUFFER_DEPTH = 16,
  parameter int unsigned P            = 64,
  localparam int unsigned GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int unsigned SW = $clog2(BUFFER_DEPTH),
  localparam int unsigned LW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_grst,
  input  logic                  i_in_valid,
  input  logic [NUM_INPUTS*P-1:0] i_data_in,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [P-1:0]          o_data_out,
  output logic [GW-1:0]         o_out_grp,
  output logic [SW-1:0]         o_out_slot,
  output logic                  o_out_last,
  output logic                  o_wr_bank,
  output logic                  o_wr_ovf,
  output logic                  o_rd_ovr
);

  typedef enum logic {StIdle, StReplay} state_e;

  state_e        r_state;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic          r_wr_ovf;
  logic          r_rd_ovr;
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_len;
  logic [GW-1:0] r_grp;
  logic [SW-1:0] r_slot;

  logic [P-1:0]  r_mem [2][NUM_INPUTS][BUFFER_DEPTH];

  logic          w_wr_bank;
  logic [LW-1:0] w_wr_ptr;
  logic [SW-1:0] w_wr_addr;
  logic          w_wr_en;
  logic          w_slot_last;
  logic          w_grp_last;
  logic          w_accept;
  logic          w_last_accept;

  // A write in the grst cycle already lands in slot 0 of the bank that opens on this edge.
  assign w_wr_bank = i_grst ? ~r_wr_bank : r_wr_bank;
  assign w_wr_ptr  = i_grst ? '0 : r_wr_ptr;
  assign w_wr_addr = w_wr_ptr[SW-1:0];
  assign w_wr_en   = i_in_valid && !i_rst && (w_wr_ptr < LW'(BUFFER_DEPTH));

  assign w_slot_last   = (LW'(r_slot) == (r_rd_len - LW'(1)));
  assign w_grp_last    = (r_grp == GW'(NUM_INPUTS - 1));
  assign w_accept      = (r_state == StReplay) && i_out_ready;
  assign w_last_accept = w_accept && w_slot_last && w_grp_last;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int g = 0; g < NUM_INPUTS; g++) begin
        r_mem[w_wr_bank][g][w_wr_addr] <= i_data_in[g*P +: P];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ovf  <= 1'b0;
      r_rd_ovr  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_len  <= '0;
      r_grp     <= '0;
      r_slot    <= '0;
    end else if (i_grst) begin
      r_wr_bank <= ~r_wr_bank;
      r_wr_ptr  <= i_in_valid ? LW'(1) : '0;
      r_rd_bank <= r_wr_bank;
      r_rd_len  <= r_wr_ptr;
      r_grp     <= '0;
      r_slot    <= '0;
      r_state   <= (r_wr_ptr != '0) ? StReplay : StIdle;
      // Accepting the final word in this same cycle means the replay did finish.
      if ((r_state == StReplay) && !w_last_accept) begin
        r_rd_ovr <= 1'b1;
      end
    end else begin
      if (i_in_valid) begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + LW'(1);
        end else begin
          r_wr_ovf <= 1'b1;
        end
      end
      if (w_accept) begin
        if (!w_slot_last) begin
          r_slot <= r_slot + SW'(1);
        end else begin
          r_slot <= '0;
          if (w_grp_last) begin
            r_grp   <= '0;
            r_state <= StIdle;
          end else begin
            r_grp <= r_grp + GW'(1);
          end
        end
      end
    end
  end

  assign o_out_valid = (r_state == StReplay);
  assign o_out_last  = o_out_valid && w_slot_last && w_grp_last;
  assign o_data_out  = o_out_valid ? r_mem[r_rd_bank][r_grp][r_slot] : '0;
  assign o_out_grp   = r_grp;
  assign o_out_slot  = r_slot;
  assign o_wr_bank   = r_wr_bank;
  assign o_wr_ovf    = r_wr_ovf;
  assign o_rd_ovr    = r_rd_ovr;

endmodule

// File: tb/tb_replay_buffer_mux.sv
// Scoreboard bench for replay_buffer_mux (P=4, NUM_INPUTS=3, BUFFER_DEPTH=8).
// The stimulus process keeps a plain queue of captured slots; at each grst it expands
// that capture into the list of words the replay must produce. A separate monitor pops
// and compares on every accepted word.
module tb_replay_buffer_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          grst = 1'b0;
  logic          in_valid = 1'b0;
  logic [11:0]   data_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    data_out;
  logic [1:0]    out_grp;
  logic [2:0]    out_slot;
  logic          out_last;
  logic          wr_bank;
  logic          wr_ovf;
  logic          rd_ovr;

  replay_buffer_mux #(
    .NUM_INPUTS  (N),
    .BUFFER_DEPTH(D),
    .P           (PW)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_grst     (grst),
    .i_in_valid (in_valid),
    .i_data_in  (data_in),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_data_out (data_out),
    .o_out_grp  (out_grp),
    .o_out_slot (out_slot),
    .o_out_last (out_last),
    .o_wr_bank  (wr_bank),
    .o_wr_ovf   (wr_ovf),
    .o_rd_ovr   (rd_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic [2:0] s;
    logic [3:0] d;
    logic       l;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] capq[$];
  logic        m_wb  = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_ovr = 1'b0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then update the reference model with what the edge consumed.
  task automatic step(input logic r, input logic gr, input logic iv, input logic [11:0] d,
                      input logic rdy);
    exp_t        e;
    logic [11:0] w;
    rst = r; grst = gr; in_valid = iv; data_in = d; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_wb = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0;
      capq.delete();
      expq.delete();
    end else if (gr) begin
      // Anything still pending here was not accepted before the boundary.
      if (expq.size() > 0) begin
        m_ovr = 1'b1;
        expq.delete();
      end
      for (int g = 0; g < N; g++) begin
        for (int s = 0; s < capq.size(); s++) begin
          w   = capq[s];
          e.g = 2'(g);
          e.s = 3'(s);
          e.d = w[g*PW +: PW];
          e.l = (g == N - 1) && (s == capq.size() - 1);
          expq.push_back(e);
        end
      end
      m_wb = ~m_wb;
      capq.delete();
      if (iv) capq.push_back(d);
    end else if (iv) begin
      if (capq.size() < D) capq.push_back(d);
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(expq.size() > 0));
      if (out_valid && expq.size() > 0) begin
        chk("out_grp",  32'(out_grp),  32'(expq[0].g));
        chk("out_slot", 32'(out_slot), 32'(expq[0].s));
        chk("data_out", 32'(data_out), 32'(expq[0].d));
        chk("out_last", 32'(out_last), 32'(expq[0].l));
        if (out_ready) void'(expq.pop_front());
      end else if (!out_valid) begin
        chk("data_out_idle", 32'(data_out), 32'h0);
        chk("out_last_idle", 32'(out_last), 32'h0);
      end
      chk("wr_bank", 32'(wr_bank), 32'(m_wb));
      chk("wr_ovf",  32'(wr_ovf),  32'(m_ovf));
      chk("rd_ovr",  32'(rd_ovr),  32'(m_ovr));
    end
  end

  initial begin
    // 1: reset, then idle
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0);
    mon_en = 1'b1;
    chk("reset_grp",  32'(out_grp),  32'h0);
    chk("reset_slot", 32'(out_slot), 32'h0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 1);

    // 2: five slots, back-to-back replay
    for (int k = 0; k < 5; k++) step(0, 0, 1, 12'hA51 + 12'(k), 1);
    step(0, 1, 0, '0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 1);

    // 3: same with ready toggling 1,0
    for (int k = 0; k < 5; k++) step(0, 0, 1, 12'hA51 + 12'(k), 1);
    step(0, 1, 0, '0, 1);
    for (int i = 0; i < 35; i++) step(0, 0, 0, '0, (i % 2) == 0);

    // 4: overflow, only the first 8 captured
    for (int k = 0; k < 10; k++) step(0, 0, 1, 12'h300 + 12'(k * 17), 1);
    step(0, 1, 0, '0, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, '0, 1);

    // 5: grst mid-replay while stalled, after 3 new writes
    for (int k = 0; k < 4; k++) step(0, 0, 1, 12'h5C0 + 12'(k), 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 12'h7E0 + 12'(k * 3), 0);
    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, '0, 1);

    // 6: empty grst swaps banks only; then rst in the middle of a replay
    step(0, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 12'h1B2 + 12'(k), 1);
    step(0, 1, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);

    // Randomised traffic including writes in the grst cycle and back-to-back boundaries
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1),
           12'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
